// File: rtl/network_tx_read_control_pkg.sv
// Shared constants for the per-port TX read controller: flag encodings,
// FSM state encoding and field widths.
package network_tx_read_control_pkg;

    localparam int unsigned BUFID_W = 9;
    localparam int unsigned OFF_W   = 7;
    localparam int unsigned ADDR_W  = BUFID_W + OFF_W;
    localparam int unsigned DATA_W  = 134;

    localparam logic [1:0] FLAG_HEAD   = 2'b01;
    localparam logic [1:0] FLAG_MID    = 2'b11;
    localparam logic [1:0] FLAG_TAIL   = 2'b10;
    localparam logic [1:0] FLAG_SINGLE = 2'b00;

    typedef enum logic [1:0] {
        NTX_IDLE    = 2'd0,
        NTX_READ    = 2'd1,
        NTX_DRAIN   = 2'd2,
        NTX_RELEASE = 2'd3
    } ntx_state_e;

    // True for the word that closes a packet (tail or single-word).
    function automatic logic is_last_flag(input logic [1:0] flag);
        logic last;
        case (flag)
            FLAG_HEAD, FLAG_MID:   last = 1'b0;
            FLAG_TAIL, FLAG_SINGLE: last = 1'b1;
            default:               last = 1'b0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/network_tx_read_control_tracker.sv
// ntx_rd_tracker: RD_LATENCY-deep shift register marking which returned
// packet-memory words correspond to issued reads.
module ntx_rd_tracker #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rd,
    output logic o_valid,
    output logic o_drained
);

    localparam logic [RD_LATENCY-1:0] PEND_MASK = {RD_LATENCY{1'b1}} >> 1;

    logic [RD_LATENCY-1:0] r_sr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr <= (r_sr << 1) | RD_LATENCY'(i_rd);
        end
    end

    assign o_valid = r_sr[RD_LATENCY-1];
    // Drained: nothing beyond the word returning this cycle is still in flight.
    assign o_drained = !i_rd && ((r_sr & PEND_MASK) == '0);

endmodule

// File: rtl/network_tx_read_control.sv
// Per-port TX read controller: fetches one buffered packet per bufid and
// streams it to the TX FIFO. Optional error counter under NTX_ERR_CNT_EN.
module network_tx_read_control
    import network_tx_read_control_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_WORDS  = 128
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [BUFID_W-1:0]  iv_pkt_bufid,
    input  logic                i_pkt_bufid_wr,
    output logic                o_pkt_bufid_ack,
    output logic [ADDR_W-1:0]   ov_pkt_raddr,
    output logic                o_pkt_rd,
    input  logic [DATA_W-1:0]   iv_pkt_rdata,
    output logic [DATA_W-1:0]   ov_data,
    output logic                o_data_wr,
    input  logic                i_tx_fifo_afull,
    output logic [BUFID_W-1:0]  ov_free_bufid,
    output logic                o_free_bufid_wr,
`ifdef NTX_ERR_CNT_EN
    output logic [15:0]         ov_err_cnt,
`endif
    output logic [1:0]          ov_ntx_state
);

    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(MAX_WORDS - 1);

    ntx_state_e          r_state, w_next;
    logic [BUFID_W-1:0]  r_bufid;
    logic [OFF_W-1:0]    r_offset;
    logic [OFF_W-1:0]    r_ret_cnt;
    logic                r_tail_seen;
    logic [DATA_W-1:0]   r_data;
    logic                r_data_wr;

    logic w_rd, w_trk_valid, w_trk_drained;
    logic w_fwd, w_flag_last, w_over, w_last_word;

    ntx_rd_tracker #(.RD_LATENCY(RD_LATENCY)) u_tracker (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_rd      (w_rd),
        .o_valid   (w_trk_valid),
        .o_drained (w_trk_drained)
    );

    assign w_rd        = (r_state == NTX_READ) && !i_tx_fifo_afull;
    assign w_fwd       = w_trk_valid && !r_tail_seen;
    assign w_flag_last = is_last_flag(iv_pkt_rdata[133:132]);
    // Word MAX_WORDS-1 always closes the packet, tail flag or not.
    assign w_over      = w_fwd && !w_flag_last && (r_ret_cnt == LAST_OFF);
    assign w_last_word = w_fwd && (w_flag_last || (r_ret_cnt == LAST_OFF));

    always_comb begin
        w_next = r_state;
        case (r_state)
            NTX_IDLE:    if (i_pkt_bufid_wr) w_next = NTX_READ;
            NTX_READ:    if (w_last_word || (w_rd && r_offset == LAST_OFF)) w_next = NTX_DRAIN;
            NTX_DRAIN:   if (w_trk_drained) w_next = NTX_RELEASE;
            NTX_RELEASE: w_next = NTX_IDLE;
            default:     w_next = NTX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= NTX_IDLE;
            r_bufid     <= '0;
            r_offset    <= '0;
            r_ret_cnt   <= '0;
            r_tail_seen <= 1'b0;
            r_data      <= '0;
            r_data_wr   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_data_wr <= w_fwd;
            if (r_state == NTX_IDLE && i_pkt_bufid_wr) begin
                r_bufid     <= iv_pkt_bufid;
                r_offset    <= '0;
                r_ret_cnt   <= '0;
                r_tail_seen <= 1'b0;
            end else begin
                if (w_rd)        r_offset    <= r_offset + 1'b1;
                if (w_fwd)       r_ret_cnt   <= r_ret_cnt + 1'b1;
                if (w_last_word) r_tail_seen <= 1'b1;
            end
            if (w_fwd) begin
                r_data <= w_over ? {FLAG_TAIL, iv_pkt_rdata[131:0]} : iv_pkt_rdata;
            end
        end
    end

`ifdef NTX_ERR_CNT_EN
    logic        w_drop;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;
    logic [15:0] r_err_cnt;

    assign w_drop    = i_pkt_bufid_wr && (r_state != NTX_IDLE);
    assign w_err_inc = {1'b0, w_drop} + {1'b0, w_over};
    assign w_err_sum = {1'b0, r_err_cnt} + {15'd0, w_err_inc};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_err_cnt <= '0;
        else          r_err_cnt <= w_err_sum[16] ? '1 : w_err_sum[15:0];
    end

    assign ov_err_cnt = r_err_cnt;
`endif

    assign o_pkt_rd        = w_rd;
    assign ov_pkt_raddr    = {r_bufid, r_offset};
    assign ov_data         = r_data;
    assign o_data_wr       = r_data_wr;
    assign o_pkt_bufid_ack = (r_state == NTX_RELEASE);
    assign o_free_bufid_wr = (r_state == NTX_RELEASE);
    assign ov_free_bufid   = (r_state == NTX_RELEASE) ? r_bufid : '0;
    assign ov_ntx_state    = r_state;

endmodule

// File: doc/network_tx_read_control.md
# network_tx_read_control

Per-port transmit-side consumer of the scheduler's bufid handshake. It accepts one pkt_bufid at a time from network_output_schedule and reads the packet's 134-bit words out of the packet buffer memory. It streams them to the port's TX FIFO, then acknowledges the scheduler and returns the bufid to the buffer free pool. There is one instance per network interface, 8 in total.

## Interface
Parameters:
- RD_LATENCY, 2: packet-memory read latency in cycles, from o_pkt_rd to valid iv_pkt_rdata.
- MAX_WORDS, 128: maximum words per packet (2048 B); the word offset is 7 bits.

Ports:
- i_clk  in  1  125 MHz clock; single clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- iv_pkt_bufid  in  9  bufid from the scheduler.
- i_pkt_bufid_wr  in  1  one-cycle strobe qualifying iv_pkt_bufid.
- o_pkt_bufid_ack  out  1  one-cycle pulse: packet fully sent, scheduler may issue the next bufid.
- ov_pkt_raddr  out  16  read address {bufid[8:0], offset[6:0]}.
- o_pkt_rd  out  1  read strobe to packet memory.
- iv_pkt_rdata  in  134  read data: [133:132] flag (01 head, 11 middle, 10 tail, 00 single), [131:128] valid bytes of the last word (0 = 16), [127:0] payload.
- ov_data  out  134  word to TX FIFO, same format as iv_pkt_rdata.
- o_data_wr  out  1  TX FIFO write strobe.
- i_tx_fifo_afull  in  1  TX FIFO almost full. The FIFO asserts it with at least RD_LATENCY+2 free slots left.
- ov_free_bufid  out  9  bufid returned to the free pool.
- o_free_bufid_wr  out  1  strobe for ov_free_bufid.
- ov_ntx_state  out  2  FSM state, for debug.
- ov_err_cnt  out  16  error counter; exists only under the macro (see Configuration).

## Operation
- FSM states: IDLE=0, READ=1, DRAIN=2, RELEASE=3.
- **IDLE**
  - On i_pkt_bufid_wr: latch the bufid, clear the offset, go to READ.
- **READ**
  - Each cycle with !i_tx_fifo_afull: assert o_pkt_rd with ov_pkt_raddr={bufid, offset}, then increment offset.
  - A shift register RD_LATENCY deep tracks which returned words are valid.
  - A returned word is forwarded only while the tail has not yet been seen.
  - On a returned word with flag 10 or 00 (tail), or when offset reaches MAX_WORDS-1 with a read issued: stop issuing reads and go to DRAIN.
  - Overlength case: if the word at offset MAX_WORDS-1 returns without a tail flag, it is forwarded with its flag forced to 10 and counts as an error.
- **DRAIN**
  - Wait until the in-flight tracker is empty.
  - Speculative reads issued after the tail are discarded and never written to the FIFO.
  - Then go to RELEASE.
- **RELEASE** (one cycle): pulse o_pkt_bufid_ack and o_free_bufid_wr with ov_free_bufid = latched bufid, then go to IDLE.
- Protocol violation: an i_pkt_bufid_wr outside IDLE is dropped, is not acknowledged, and counts as an error.
- ov_data and o_data_wr are registered copies of the returned word and its valid bit.
- Reset mid-packet: all state is cleared, no ack and no free are issued, and the bufid is abandoned. Reset is system-wide, and the buffer manager re-initialises its free pool.
- Reset values: all outputs are 0 and the FSM is in IDLE.

## Timing
- Strobe at cycle 0 (IDLE): first o_pkt_rd at cycle 1, first o_data_wr at cycle 2+RD_LATENCY.
- Without backpressure, an N-word packet produces one word per cycle. The tail is written at cycle 1+N+RD_LATENCY, and ack/free are pulsed at cycle 3+N+RD_LATENCY.
- i_tx_fifo_afull only gates new reads. Reads already in flight still complete and write to the FIFO.
- Ack and free always coincide. There is at most one outstanding bufid.

## Configuration
- Macro NTX_ERR_CNT_EN.
- When defined: ov_err_cnt increments on each dropped strobe and each overlength packet. It saturates at 0xFFFF and resets to 0.
- When undefined: the counter and the port are absent, and both error conditions are handled identically but silently.

## Structure
- Shared package: flag encodings (FLAG_HEAD, FLAG_MID, FLAG_TAIL, FLAG_SINGLE), FSM state encodings, and the width constants for bufid (9), offset (7) and data (134).
- Natural sub-module: ntx_rd_tracker, the RD_LATENCY-deep valid shift register with an empty flag.

## Test plan
- Single-word packet: bufid 0x05 with flag 00 → one write with the flag kept at 00; ack and free (0x05) at cycle 3+1+2=6.
- Four-word packet: bufid 0x1A, no backpressure → writes with flags 01,11,11,10 at cycles 4–7; reads to 0x0D00–0x0D03 plus 2 discarded reads; ack at cycle 9.
- Backpressure: i_tx_fifo_afull held high for cycles 3–7 in a 10-word packet → no o_pkt_rd in cycles 3–7; all 10 words delivered in order; ack and free once.
- Overlength: 128 words with no tail flag → word 127 written with flag 10; ack issued; ov_err_cnt=1 with the macro defined.
- Strobe during READ: a second bufid 0x33 is ignored; only the first bufid is freed and acked; ov_err_cnt increments.
- Reset asserted mid-packet → all outputs 0 and ov_ntx_state=0 asynchronously; no ack or free; a new bufid after reset is processed normally.
